// File: rtl/flog_pkg.sv
// Shared constants and types for the flog float<->fixed datapath.
// Widths, exponent thresholds, Q8.8 saturation words and the f2i FSM states.
package flog_pkg;

  localparam int EXP_WIDTH      = 8;
  localparam int FRACT_WIDTH    = 7;
  localparam int INT_WIDTH      = 8;
  localparam int FRAC_OUT_WIDTH = 8;
  localparam int ACC_WIDTH      = INT_WIDTH + FRAC_OUT_WIDTH;
  localparam int CNT_WIDTH      = 4;

  localparam logic [EXP_WIDTH-1:0] BIAS          = 8'd127;
  localparam logic [EXP_WIDTH-1:0] EXP_SPECIAL   = 8'hFF;
  // Smallest exponent whose magnitude no longer fits in signed Q8.8 (>= 128.0)
  localparam logic [EXP_WIDTH-1:0] EXP_SAT_MIN   = 8'd134;
  // Below this exponent the value truncates to zero after the right shift
  localparam logic [EXP_WIDTH-1:0] EXP_RIGHT_MIN = 8'd118;

  localparam logic [ACC_WIDTH-1:0] SAT_POS = 16'h7FFF;
  localparam logic [ACC_WIDTH-1:0] SAT_NEG = 16'h8000;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PACK
  } f2i_state_e;

endpackage

// File: rtl/f2i_classify.sv
// Combinational operand decoder for f2i: picks saturation/zero handling,
// shift direction and shift count from the bfloat16 fields.
import flog_pkg::*;

module f2i_classify (
  input  logic                   sgn_i,
  input  logic [EXP_WIDTH-1:0]   exp_i,
  input  logic [FRACT_WIDTH-1:0] mantissa_i,
  output logic                   sat_o,
  output logic                   ovf_o,
  output logic                   zero_o,
  output logic                   dir_left_o,
  output logic [CNT_WIDTH-1:0]   n_o
);

  always_comb begin
    sat_o      = 1'b0;
    ovf_o      = 1'b0;
    zero_o     = 1'b0;
    dir_left_o = 1'b0;
    n_o        = '0;
    if (exp_i == '0) begin
      zero_o = 1'b1;
    end else if (exp_i == EXP_SPECIAL || exp_i >= EXP_SAT_MIN) begin
      sat_o = 1'b1;
      // -128.0 is the one out-of-range magnitude that is exactly representable
      ovf_o = !(sgn_i && exp_i == EXP_SAT_MIN && mantissa_i == '0);
    end else if (exp_i >= BIAS) begin
      dir_left_o = 1'b1;
      n_o        = CNT_WIDTH'(exp_i - BIAS);
    end else if (exp_i >= EXP_RIGHT_MIN) begin
      n_o = CNT_WIDTH'(BIAS - exp_i);
    end else begin
      zero_o = 1'b1;
    end
  end

endmodule

// File: rtl/f2i.sv
// bfloat16 to signed Q8.8 converter: bit-serial shifter, one shift per clock,
// IDLE/SHIFT/PACK FSM with valid/ready handshake.
import flog_pkg::*;

module f2i (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      valid_f2i_i,
  output logic                      ready_f2i_o,
  input  logic                      sgn_i,
  input  logic [EXP_WIDTH-1:0]      exp_i,
  input  logic [FRACT_WIDTH-1:0]    mantissa_i,
  output logic [INT_WIDTH-1:0]      parte_intera_o,
  output logic [FRAC_OUT_WIDTH-1:0] parte_frazionaria_o,
  output logic                      ovf_o,
  output logic                      valid_f2i_o
);

  f2i_state_e                state_q, state_d;
  logic [ACC_WIDTH-1:0]      acc_q, acc_d;
  logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;
  logic                      dir_q, dir_d;
  logic                      sgn_q, sgn_d;
  logic                      sat_q, sat_d;
  logic                      ovf_flag_q, ovf_flag_d;
  logic [INT_WIDTH-1:0]      int_q, int_d;
  logic [FRAC_OUT_WIDTH-1:0] frac_q, frac_d;
  logic                      ovf_q, ovf_d;
  logic                      valid_q, valid_d;
  logic [ACC_WIDTH-1:0]      res;

  logic                      cls_sat, cls_ovf, cls_zero, cls_left;
  logic [CNT_WIDTH-1:0]      cls_n;

  f2i_classify u_classify (
    .sgn_i      (sgn_i),
    .exp_i      (exp_i),
    .mantissa_i (mantissa_i),
    .sat_o      (cls_sat),
    .ovf_o      (cls_ovf),
    .zero_o     (cls_zero),
    .dir_left_o (cls_left),
    .n_o        (cls_n)
  );

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    dir_d      = dir_q;
    sgn_d      = sgn_q;
    sat_d      = sat_q;
    ovf_flag_d = ovf_flag_q;
    int_d      = int_q;
    frac_d     = frac_q;
    ovf_d      = ovf_q;
    valid_d    = 1'b0;
    res        = '0;
    case (state_q)
      IDLE: begin
        if (valid_f2i_i) begin
          sgn_d      = sgn_i;
          sat_d      = cls_sat;
          ovf_flag_d = cls_ovf;
          dir_d      = cls_left;
          cnt_d      = cls_n;
          // Hidden one lands on bit 8 so the loaded value is 1.m in Q8.8
          acc_d      = (cls_zero || cls_sat) ? '0 :
                       {{(ACC_WIDTH-FRACT_WIDTH-2){1'b0}}, 1'b1, mantissa_i, 1'b0};
          state_d    = (cls_n != '0) ? SHIFT : PACK;
        end
      end
      SHIFT: begin
        acc_d = dir_q ? (acc_q << 1) : (acc_q >> 1);
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_WIDTH'(1)) state_d = PACK;
      end
      PACK: begin
        if (sat_q) res = sgn_q ? SAT_NEG : SAT_POS;
        else       res = sgn_q ? (~acc_q + 1'b1) : acc_q;
        int_d   = res[ACC_WIDTH-1:FRAC_OUT_WIDTH];
        frac_d  = res[FRAC_OUT_WIDTH-1:0];
        ovf_d   = ovf_flag_q;
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      dir_q      <= 1'b0;
      sgn_q      <= 1'b0;
      sat_q      <= 1'b0;
      ovf_flag_q <= 1'b0;
      int_q      <= '0;
      frac_q     <= '0;
      ovf_q      <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      dir_q      <= dir_d;
      sgn_q      <= sgn_d;
      sat_q      <= sat_d;
      ovf_flag_q <= ovf_flag_d;
      int_q      <= int_d;
      frac_q     <= frac_d;
      ovf_q      <= ovf_d;
      valid_q    <= valid_d;
    end
  end

  assign ready_f2i_o         = (state_q == IDLE);
  assign parte_intera_o      = int_q;
  assign parte_frazionaria_o = frac_q;
  assign ovf_o               = ovf_q;
  assign valid_f2i_o         = valid_q;

endmodule

// File: doc/f2i.md
Name: f2i

Overview:
- Converts a bfloat16 operand (sign, 8-bit biased exponent, 7-bit mantissa) into a signed Q8.8 fixed-point value, split into an integer byte and a fraction byte.
- It is the inverse of the fixed-to-float converter in the flog datapath and feeds results back into the integer/fraction domain.
- It is a multi-cycle, bit-serial shifter: one shift per clock, controlled by a 3-state FSM with a valid/ready handshake.

Parameters:
- EXP_WIDTH, 8, biased exponent width (from flog_pkg)
- FRACT_WIDTH, 7, stored mantissa width (from flog_pkg)
- INT_WIDTH, 8, output integer part width, two's complement
- FRAC_OUT_WIDTH, 8, output fraction part width
- BIAS, 127, exponent bias

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- valid_f2i_i  in  1  input operand valid
- ready_f2i_o  in/out: out  1  block can accept; equals (state==IDLE)
- sgn_i  in  1  operand sign
- exp_i  in  EXP_WIDTH  biased exponent
- mantissa_i  in  FRACT_WIDTH  stored mantissa, hidden 1 implied
- parte_intera_o  out  INT_WIDTH  high byte of the Q8.8 two's-complement result
- parte_frazionaria_o  out  FRAC_OUT_WIDTH  low byte of the Q8.8 result
- ovf_o  out  1  result saturated
- valid_f2i_o  out  1  one-cycle pulse: outputs are valid

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; shift register, count and all outputs go to 0.
  - ready_f2i_o=1 once rst=1.
- Internal registers: acc[15:0] (magnitude in Q8.8), cnt[3:0], dir (left/right), sgn, special flags.
- IDLE: on a clock edge with valid_f2i_i=1, the operand is sampled and classified as follows.
  - exp_i==0 (zero/denormal): acc=0, N=0, go to PACK.
  - exp_i==255 (inf/NaN): saturate per sign, ovf=1, N=0, go to PACK.
  - exp_i in 134..254: saturate per sign, ovf=1, N=0, go to PACK.
  - Exception: sgn=1, exp=134, mantissa=0 is exactly -128, giving result 0x8000 with ovf=0.
  - exp_i in 127..133: acc={7'b0,1,mantissa,1'b0} (1.m at bits 8..1); dir=left; N=exp-127 (0..6).
  - exp_i in 118..126: same acc load; dir=right; N=127-exp (1..9).
  - exp_i in 1..117: result 0, N=0, go to PACK.
  - Next state is SHIFT if N>0, else PACK.
- SHIFT: each cycle acc is shifted one bit in dir (zero fill) and cnt decrements. When cnt reaches 1, the next state is PACK.
- PACK (one cycle):
  - res = sgn ? (~acc+1) : acc, truncated toward zero in magnitude. Negative zero gives 0.
  - Saturation values: 0x7FFF for positive, 0x8000 for negative.
  - At the edge leaving PACK, the block registers parte_intera_o=res[15:8], parte_frazionaria_o=res[7:0] and ovf_o, sets valid_f2i_o=1, and sets state=IDLE.
- Outputs hold until the next PACK. valid_f2i_o is high for exactly one cycle.
- Latency: the result is visible N+1 cycles after the accepting edge (N=0..9).
  - A new operand can be accepted in the same cycle valid_f2i_o is high.
  - Throughput is one result per N+2 cycles.
- valid_f2i_i while ready_f2i_o=0 is ignored; there is no queuing.
- Inputs are only sampled in IDLE and may change freely afterwards.
- Reset asserted mid-SHIFT/PACK aborts the operation immediately. No valid pulse follows.

Decomposition:
- flog_pkg: EXP_WIDTH, FRACT_WIDTH, BIAS, INT_WIDTH, FRAC_OUT_WIDTH, the Q8.8 saturation constants (SAT_POS=16'h7FFF, SAT_NEG=16'h8000) and an f2i state enum (IDLE, SHIFT, PACK).
- One natural sub-module: f2i_classify, a combinational decoder that produces special/zero/ovf flags, dir and N from sgn/exp/mantissa.

Test Plan:
- 0x3F80 (1.0) -> int 0x01, frac 0x00, ovf 0, valid 1 cycle after accept.
- 0xC020 (-2.5) -> int 0xFD, frac 0x80, ovf 0, latency 2.
- 0x3F40 (0.75) -> int 0x00, frac 0xC0, latency 2; 0x3B80 (2^-8) -> 0x00/0x01, latency 9; 0x3B00 (2^-9) -> 0x00/0x00, latency 10.
- 0x4348 (200.0) -> 0x7F/0xFF, ovf 1; 0xC300 (-128.0) -> 0x80/0x00, ovf 0; 0xFF80 (-inf) -> 0x80/0x00, ovf 1; all latency 1.
- 0x0000 and 0x8000 -> 0x00/0x00, ovf 0. Back-to-back valid with a new operand on the valid_f2i_o cycle -> accepted, correct second result.
- Start 0x3B80, drive valid_f2i_i with another operand during SHIFT -> ignored. Pull rst low at SHIFT cycle 3 -> outputs 0, no valid pulse, ready_f2i_o=1 after release.
